imem_fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer in front of the 64-word instruction memory. IMEM is asynchronous-read and word-indexed; its 8-bit address selects the word directly.
- Holds the program counter, which advances by 1 word per fetch.
- Drives the IMEM address and registers each returned word into a one-entry output buffer with a valid/ready handshake to decode.
- Handles start, halt, branch redirect and end-of-program detection.

---
 rtl/imem_fetch_ctrl_if.sv | 22 ++
 rtl/imem_fetch_ctrl.sv | 149 ++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-side bus: IMEM address/data plus the one-entry instruction buffer handshake to decode.
// master = fetch controller, slave = IMEM + decode side.
interface imem_fetch_ctrl_if #(
    parameter int unsigned ADDR_W = 8
);
    logic [ADDR_W-1:0] IMEM_PC;
    logic [31:0]       IMEM_instruction;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst_out;
    logic [ADDR_W-1:0] inst_pc;

    modport master (
        output IMEM_PC, inst_valid, inst_out, inst_pc,
        input  IMEM_instruction, inst_ready
    );

    modport slave (
        input  IMEM_PC, inst_valid, inst_out, inst_pc,
        output IMEM_instruction, inst_ready
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: PC, asynchronous-read IMEM addressing and a one-entry
// valid/ready output buffer, with start/halt/redirect and end-of-program handling.
module imem_fetch_ctrl #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DEPTH        = 64,
    parameter int unsigned RESET_PC     = 0,
    parameter int unsigned STOP_ON_ZERO = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    imem_fetch_ctrl_if.master bus,
    output logic [7:0]        inst_count,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic [31:0]       inst_out_q, inst_out_d;
    logic              inst_valid_q, inst_valid_d;
    logic [7:0]        count_q, count_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic xfer;
    logic loadable;
    logic redirect_ok;
    logic at_last;
    logic zero_word;

    assign xfer        = inst_valid_q & bus.inst_ready;
    assign loadable    = ~inst_valid_q | bus.inst_ready;
    assign redirect_ok = 32'(redirect_pc) < DEPTH;
    assign at_last     = 32'(pc_q) == (DEPTH - 1);
    assign zero_word   = (STOP_ON_ZERO != 0) && (bus.IMEM_instruction == '0);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_pc_d    = inst_pc_q;
        inst_out_d   = inst_out_q;
        inst_valid_d = inst_valid_q;
        count_d      = count_q;
        err_d        = err_q;

        // A completed handoff empties the buffer unless a load below refills it.
        if (xfer) begin
            inst_valid_d = 1'b0;
            if (count_q != '1) begin
                count_d = count_q + 8'd1;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = ADDR_W'(RESET_PC);
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (halt) begin
                    state_d = S_DRAIN;
                end else if (redirect_valid) begin
                    inst_valid_d = 1'b0;
                    if (redirect_ok) begin
                        pc_d = redirect_pc;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DRAIN;
                    end
                end else if (loadable) begin
                    if (zero_word) begin
                        state_d = S_DRAIN;
                    end else begin
                        inst_out_d   = bus.IMEM_instruction;
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                        // Last word: stop here rather than wrapping to 0.
                        if (at_last) begin
                            state_d = S_DRAIN;
                        end else begin
                            pc_d = pc_q + 1'b1;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (!inst_valid_q || xfer) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= ADDR_W'(RESET_PC);
            inst_pc_q    <= '0;
            inst_out_q   <= '0;
            inst_valid_q <= 1'b0;
            count_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_pc_q    <= inst_pc_d;
            inst_out_q   <= inst_out_d;
            inst_valid_q <= inst_valid_d;
            count_q      <= count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.IMEM_PC    = pc_q;
    assign bus.inst_valid = inst_valid_q;
    assign bus.inst_out   = inst_out_q;
    assign bus.inst_pc    = inst_pc_q;
    assign inst_count     = count_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: table of program/ready-pattern scenarios, hand-written corner
// sequences, and random programs checked against an in-order delivery model of IMEM.
module tb_imem_fetch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       halt = 1'b0;
    logic       redirect_valid = 1'b0;
    logic [7:0] redirect_pc = '0;
    logic [7:0] inst_count;
    logic       busy;
    logic       done;
    logic       err;

    logic [31:0] mem [64];

    int n_cmp = 0;
    int n_bad = 0;

    int          exp_pc_q[$];
    logic [31:0] exp_w_q[$];
    int          got_pc_q[$];
    logic [31:0] got_w_q[$];

    typedef struct {
        int zero_at;
        int ready_mode;
        int exp_count;
        int exp_pc;
    } vec_t;

    vec_t vecs[5];

    imem_fetch_ctrl_if #(.ADDR_W(8)) bus ();

    assign bus.IMEM_instruction = (bus.IMEM_PC < 8'd64) ? mem[bus.IMEM_PC[5:0]] : 32'h0;

    imem_fetch_ctrl #(
        .ADDR_W(8),
        .DEPTH(64),
        .RESET_PC(0),
        .STOP_ON_ZERO(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .halt(halt),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .bus(bus),
        .inst_count(inst_count),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Reference: the program is delivered in address order up to the first zero word or the last word.
    task automatic build_model();
        exp_pc_q.delete();
        exp_w_q.delete();
        for (int i = 0; i < 64; i++) begin
            if (mem[i] == 32'h0) break;
            exp_pc_q.push_back(i);
            exp_w_q.push_back(mem[i]);
        end
    endtask

    // mode 0: ready always; mode k>0: ready every k-th cycle; mode <0: random ready.
    task automatic collect(input int mode);
        got_pc_q.delete();
        got_w_q.delete();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (done) break;
            if (mode == 0) bus.inst_ready = 1'b1;
            else if (mode > 0) bus.inst_ready = ((cyc % mode) == 0);
            else bus.inst_ready = 1'($urandom);
            if (bus.inst_valid && bus.inst_ready) begin
                got_pc_q.push_back(int'(bus.inst_pc));
                got_w_q.push_back(bus.inst_out);
            end
            tick();
        end
        chk("done_within_budget", 32'(done), 32'd1);
    endtask

    task automatic compare_sb(input string name);
        chk({name, "_n_transfers"}, 32'(got_pc_q.size()), 32'(exp_pc_q.size()));
        for (int i = 0; i < exp_pc_q.size() && i < got_pc_q.size(); i++) begin
            chk({name, "_pc"}, 32'(got_pc_q[i]), 32'(exp_pc_q[i]));
            chk({name, "_word"}, got_w_q[i], exp_w_q[i]);
        end
    endtask

    task automatic load_test_prog();
        for (int i = 0; i < 64; i++) mem[i] = 32'hFFFF_FFFF;
        mem[0] = 32'h2008_0001;
        mem[1] = 32'h2009_0002;
        mem[2] = 32'h0109_5020;
        mem[3] = 32'h0000_0000;
    endtask

    initial begin
        int k;
        int zpos;
        int fpc;

        bus.inst_ready = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
        vecs[0] = '{3, 0, 3, 3};
        vecs[1] = '{0, 0, 0, 0};
        vecs[2] = '{64, 0, 64, 63};
        vecs[3] = '{10, 3, 10, 10};
        vecs[4] = '{63, 2, 63, 63};

        #12 rst_n = 1'b1;
        tick();
        chk("rst_pc", 32'(bus.IMEM_PC), 32'd0);
        chk("rst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_out", bus.inst_out, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(inst_count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // Basic program, ready held high: one transfer per clock.
        load_test_prog();
        bus.inst_ready = 1'b1;
        do_start();
        chk("seq1_busy", 32'(busy), 32'd1);
        chk("seq1_valid0", 32'(bus.inst_valid), 32'd0);
        tick();
        chk("seq1_out0", bus.inst_out, 32'h2008_0001);
        chk("seq1_ipc0", 32'(bus.inst_pc), 32'd0);
        chk("seq1_imempc1", 32'(bus.IMEM_PC), 32'd1);
        tick();
        chk("seq1_out1", bus.inst_out, 32'h2009_0002);
        chk("seq1_ipc1", 32'(bus.inst_pc), 32'd1);
        tick();
        chk("seq1_out2", bus.inst_out, 32'h0109_5020);
        chk("seq1_ipc2", 32'(bus.inst_pc), 32'd2);
        tick();
        chk("seq1_drain_valid", 32'(bus.inst_valid), 32'd0);
        chk("seq1_drain_busy", 32'(busy), 32'd1);
        tick();
        chk("seq1_done", 32'(done), 32'd1);
        chk("seq1_idle_busy", 32'(busy), 32'd0);
        chk("seq1_count", 32'(inst_count), 32'd3);

        // Decode stalls for 4 cycles after the first load.
        build_model();
        bus.inst_ready = 1'b0;
        do_start();
        tick();
        for (int c = 0; c < 4; c++) begin
            chk("stall_valid", 32'(bus.inst_valid), 32'd1);
            chk("stall_out", bus.inst_out, 32'h2008_0001);
            chk("stall_ipc", 32'(bus.inst_pc), 32'd0);
            chk("stall_imempc", 32'(bus.IMEM_PC), 32'd1);
            tick();
        end
        collect(0);
        compare_sb("stall");
        chk("stall_count", 32'(inst_count), 32'd3);

        // Table-driven programs: zero-word position and ready pattern.
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i);
            if (vecs[v].zero_at < 64) mem[vecs[v].zero_at] = 32'h0;
            build_model();
            do_start();
            collect(vecs[v].ready_mode);
            compare_sb("table");
            chk("table_count", 32'(inst_count), 32'(vecs[v].exp_count));
            chk("table_final_pc", 32'(bus.IMEM_PC), 32'(vecs[v].exp_pc));
            chk("table_busy", 32'(busy), 32'd0);
        end

        // Redirect while the buffer holds pc 5 and decode is stalled.
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
        bus.inst_ready = 1'b1;
        do_start();
        k = 0;
        while (!(bus.inst_valid && bus.inst_pc == 8'd5) && k < 20) begin
            tick();
            k++;
        end
        chk("redir_reached_pc5", 32'(k < 20), 32'd1);
        chk("redir_count_before", 32'(inst_count), 32'd5);
        bus.inst_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 8'd10;
        tick();
        redirect_valid = 1'b0;
        chk("redir_flushed", 32'(bus.inst_valid), 32'd0);
        chk("redir_pc", 32'(bus.IMEM_PC), 32'd10);
        chk("redir_count", 32'(inst_count), 32'd5);
        tick();
        chk("redir_ipc", 32'(bus.inst_pc), 32'd10);
        chk("redir_out", bus.inst_out, 32'h1000_000A);
        chk("redir_valid", 32'(bus.inst_valid), 32'd1);
        halt = 1'b1;
        bus.inst_ready = 1'b1;
        tick();
        halt = 1'b0;
        chk("halt_count", 32'(inst_count), 32'd6);
        chk("halt_busy", 32'(busy), 32'd1);
        tick();
        chk("halt_done", 32'(done), 32'd1);

        // Redirect out of range: sticky error, drain, then start clears it.
        do_start();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 8'd70;
        tick();
        redirect_valid = 1'b0;
        chk("err_set", 32'(err), 32'd1);
        chk("err_noload", 32'(bus.inst_valid), 32'd0);
        chk("err_pc_held", 32'(bus.IMEM_PC), 32'd2);
        chk("err_busy", 32'(busy), 32'd1);
        tick();
        chk("err_done", 32'(done), 32'd1);
        chk("err_sticky", 32'(err), 32'd1);
        do_start();
        chk("err_cleared", 32'(err), 32'd0);
        chk("err_count_cleared", 32'(inst_count), 32'd0);

        // halt and redirect in the same cycle: halt wins.
        bus.inst_ready = 1'b0;
        tick();
        halt = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 8'd20;
        tick();
        halt = 1'b0;
        redirect_valid = 1'b0;
        chk("hr_pc", 32'(bus.IMEM_PC), 32'd1);
        chk("hr_valid", 32'(bus.inst_valid), 32'd1);
        chk("hr_ipc", 32'(bus.inst_pc), 32'd0);
        chk("hr_busy", 32'(busy), 32'd1);
        chk("hr_notdone", 32'(done), 32'd0);
        bus.inst_ready = 1'b1;
        tick();
        chk("hr_done", 32'(done), 32'd1);
        chk("hr_count", 32'(inst_count), 32'd1);

        // Asynchronous reset in the middle of RUN.
        do_start();
        tick();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.inst_valid), 32'd0);
        chk("arst_out", bus.inst_out, 32'd0);
        chk("arst_ipc", 32'(bus.inst_pc), 32'd0);
        chk("arst_pc", 32'(bus.IMEM_PC), 32'd0);
        chk("arst_count", 32'(inst_count), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 8'd70;
        halt = 1'b1;
        tick();
        redirect_valid = 1'b0;
        halt = 1'b0;
        chk("idle_ignore_err", 32'(err), 32'd0);
        chk("idle_ignore_pc", 32'(bus.IMEM_PC), 32'd0);
        chk("idle_ignore_busy", 32'(busy), 32'd0);

        // Random programs with random decode backpressure.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 64; i++) mem[i] = $urandom | 32'h1;
            zpos = int'($urandom_range(0, 80));
            if (zpos < 64) mem[zpos] = 32'h0;
            build_model();
            fpc = (exp_pc_q.size() == 64) ? 63 : exp_pc_q.size();
            do_start();
            collect(-1);
            compare_sb("rand");
            chk("rand_count", 32'(inst_count), 32'(exp_pc_q.size()));
            chk("rand_final_pc", 32'(bus.IMEM_PC), 32'(fpc));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
